// File: rtl/eth_tx_frame_fifo.sv
// eth_tx_frame_fifo
//   Byte buffer and frame gate in front of the Ethernet TX nibble serializer.
//   Payload bytes from the video packer are stored in a circular buffer.
//   send_enable is raised only once a whole frame (FRAME_BYTES) is resident.
//   The head byte is presented first-word-fall-through for the serializer
//   to pop. A minimum inter-frame gap is enforced, and overflow/underrun are
//   reported as sticky flags.
//
// Ports
//   clk          25 MHz clock, shared with the serializer
//   rst          synchronous, active-high reset
//   wr_data      payload byte from the packer
//   wr_en        write strobe, one byte per cycle
//   full         level == DEPTH
//   rd_en        serializer pops the current rd_data byte
//   rd_data      FWFT head byte (mem[rd_ptr])
//   rd_valid     level != 0
//   send_enable  high while a frame is offered or streaming (READY/STREAM)
//   level        bytes resident
//   frames_sent  completed frames, wraps at 16 bits
//   overflow     sticky: write attempted while full
//   underrun     sticky: pop attempted while empty or outside a frame
//   err_clr      clears both sticky flags (a same-cycle set wins)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a full frame's worth of bytes to be resident
// READY  | frame resident, send_enable high, no byte popped yet
// STREAM | frame in progress, byte_cnt bytes popped so far
// GAP    | inter-frame gap, gap_cnt counts down to zero

module eth_tx_frame_fifo #(
  parameter int DEPTH       = 4096,
  parameter int ADDR_W      = 12,
  parameter int FRAME_BYTES = 1350,
  parameter int IFG_CYCLES  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              send_enable,
  output logic [ADDR_W:0]   level,
  output logic [15:0]       frames_sent,
  output logic              overflow,
  output logic              underrun,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(FRAME_BYTES + 1);
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  localparam logic [ADDR_W:0]  DEPTH_LVL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  FRAME_LVL  = (ADDR_W + 1)'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BYTES - 1);
  // Gap counter is loaded with IFG_CYCLES-1 and leaves GAP when it reads
  // zero, so GAP lasts exactly IFG_CYCLES cycles.
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              frame_done;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic              in_frame;
  logic              wr_ok;
  logic              pop_ok;

  assign full     = (level == DEPTH_LVL);
  assign rd_valid = (level != '0);
  assign rd_data  = mem[rd_ptr];

  assign in_frame = (state == READY) || (state == STREAM);
  assign wr_ok    = wr_en && !full;
  assign pop_ok   = rd_en && rd_valid && in_frame;

  // Storage is not reset; a reset discards contents by clearing pointers.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Full check uses the registered level, so a pop in the same cycle does
  // not make room for that cycle's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_ok, pop_ok})
        2'b10:   level <= level + (ADDR_W + 1)'(1);
        2'b01:   level <= level - (ADDR_W + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      frames_sent <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      if (frame_done) begin
        frames_sent <= frames_sent + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    frame_done   = 1'b0;
    send_enable  = 1'b0;
    case (state)
      IDLE: begin
        // Compare against registered level: one cycle from level reaching
        // a full frame to send_enable.
        if (level >= FRAME_LVL) begin
          state_nxt = READY;
        end
      end
      READY, STREAM: begin
        send_enable = 1'b1;
        if (pop_ok) begin
          if (byte_cnt == FRAME_LAST) begin
            state_nxt    = GAP;
            byte_cnt_nxt = '0;
            gap_cnt_nxt  = GAP_LOAD;
            frame_done   = 1'b1;
          end else begin
            state_nxt    = STREAM;
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sticky flags: a set in the same cycle as err_clr takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overflow <= (wr_en && full) || (overflow && !err_clr);
      underrun <= (rd_en && !pop_ok) || (underrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
module tb_eth_tx_frame_fifo;

  localparam int DEPTH       = 4096;
  localparam int ADDR_W      = 12;
  localparam int FRAME_BYTES = 1350;
  localparam int IFG_CYCLES  = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            full;
  logic            rd_en;
  logic [7:0]      rd_data;
  logic            rd_valid;
  logic            send_enable;
  logic [ADDR_W:0] level;
  logic [15:0]     frames_sent;
  logic            overflow;
  logic            underrun;
  logic            err_clr;

  always #20 clk = ~clk;

  eth_tx_frame_fifo #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .FRAME_BYTES(FRAME_BYTES),
    .IFG_CYCLES(IFG_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .send_enable(send_enable),
    .level(level),
    .frames_sent(frames_sent),
    .overflow(overflow),
    .underrun(underrun),
    .err_clr(err_clr)
  );

  // Reference model: byte queue plus frame-level bookkeeping.
  logic [7:0] q[$];
  bit         m_frame;    // frame offered/streaming
  int         m_popped;   // bytes popped in current frame
  int         m_gap;      // gap cycles still to elapse
  int         m_frames;
  bit         m_ovf;
  bit         m_und;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_frame  = 1'b0;
    m_popped = 0;
    m_gap    = 0;
    m_frames = 0;
    m_ovf    = 1'b0;
    m_und    = 1'b0;
  endtask

  task automatic check_outputs();
    check("send_enable", send_enable, m_frame);
    check("rd_valid", rd_valid, q.size() != 0);
    check("level", level, q.size());
    check("full", full, q.size() == DEPTH);
    check("frames_sent", frames_sent, m_frames);
    check("overflow", overflow, m_ovf);
    check("underrun", underrun, m_und);
    if (q.size() > 0) check("rd_data", rd_data, q[0]);
  endtask

  task automatic step(input bit w, input bit r, input bit clr, input bit rs);
    logic [7:0] d;
    int  lvl;
    bit  wacc, pacc, ovf_set, und_set;
    d       = 8'($urandom);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    err_clr = clr;
    rst     = rs;
    lvl     = q.size();
    wacc    = w && (lvl < DEPTH);
    pacc    = r && (lvl > 0) && m_frame;
    ovf_set = w && (lvl == DEPTH);
    und_set = r && !pacc;
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (pacc) void'(q.pop_front());
      if (wacc) q.push_back(d);
      m_ovf = ovf_set || (m_ovf && !clr);
      m_und = und_set || (m_und && !clr);
      if (pacc) begin
        m_popped++;
        if (m_popped == FRAME_BYTES) begin
          m_frame  = 1'b0;
          m_popped = 0;
          m_frames = (m_frames + 1) % 65536;
          m_gap    = IFG_CYCLES;
        end
      end else if (!m_frame) begin
        if (m_gap > 0) m_gap--;
        else if (lvl >= FRAME_BYTES) m_frame = 1'b1;
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    int low_run;
    int ngaps;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
    model_reset();

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("rst_level", level, 0);
    check("rst_send", send_enable, 0);

    // One byte short of a frame, then the completing byte
    repeat (FRAME_BYTES - 1) step(1, 0, 0, 0);
    check("a_send_short", send_enable, 0);
    step(1, 0, 0, 0);
    check("a_send_compare", send_enable, 0);
    step(0, 0, 0, 0);
    check("a_send_hi", send_enable, 1);

    // Pop one byte every other cycle until the frame completes
    for (int i = 0; i < 4 * FRAME_BYTES && m_frames < 1; i++) step(0, (i % 2) == 0, 0, 0);
    check("b_frames", frames_sent, 1);
    check("b_level", level, 0);
    check("b_send", send_enable, 0);

    // Preload two frames, then stream back-to-back with background writes
    repeat (2 * FRAME_BYTES) step(1, 0, 0, 0);
    low_run = 0;
    ngaps   = 0;
    for (int i = 0; i < 4 * FRAME_BYTES && m_frames < 3; i++) begin
      step(($urandom % 2) == 0, m_frame, 0, 0);
      if (!send_enable) low_run++;
      else begin
        if (low_run > 0) begin
          check("c_gap_len", low_run, IFG_CYCLES + 1);
          ngaps++;
        end
        low_run = 0;
      end
    end
    check("c_frames", frames_sent, 3);
    check("c_gaps_seen", ngaps, 1);

    // Random traffic, occasional illegal pops and flag clears
    for (int i = 0; i < 6000; i++) begin
      step(($urandom % 10) < 6,
           m_frame ? (($urandom % 2) == 0) : (($urandom % 20) == 0),
           ($urandom % 50) == 0, 0);
    end

    // Fill to full, then a simultaneous write and pop
    step(0, 0, 0, 1);
    repeat (DEPTH) step(1, 0, 0, 0);
    check("e_full", full, 1);
    check("e_level_full", level, DEPTH);
    check("e_ovf_before", overflow, 0);
    step(1, 1, 0, 0);
    check("e_ovf", overflow, 1);
    check("e_level_after", level, DEPTH - 1);
    step(0, 0, 1, 0);
    check("e_ovf_clr", overflow, 0);

    // Illegal pop in IDLE with 10 bytes resident
    step(0, 0, 0, 1);
    repeat (10) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    check("f_underrun", underrun, 1);
    check("f_level", level, 10);
    check("f_send", send_enable, 0);

    // Reset in the middle of the second frame
    step(0, 0, 0, 1);
    repeat (2 * FRAME_BYTES) step(1, 0, 0, 0);
    for (int i = 0; i < 4 * FRAME_BYTES && !(m_frames == 1 && m_popped == 500); i++)
      step(0, m_frame, 0, 0);
    check("g_pre_frames", frames_sent, 1);
    check("g_pre_level", level, FRAME_BYTES - 500);
    step(0, 0, 0, 1);
    check("g_send", send_enable, 0);
    check("g_level", level, 0);
    check("g_frames", frames_sent, 0);
    check("g_valid", rd_valid, 0);
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
